hcode_fifo_arbiter_4ch: RTL

Round-robin arbiter that merges four ap_fifo source channels (128-bit, first-word-fall-through, `empty_n`/`read`) onto one ap_fifo sink (`full_n`/`write`). It lets the four host channels of the shell share a single subshell IP input port. Grants are held for a burst of up to BURST_MAX beats. The datapath is zero-latency pass-through, and all sequencing is in a registered grant FSM.

---
 rtl/hcode_fifo_arbiter_4ch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hcode_fifo_arbiter_4ch.sv
// Four-channel round-robin ap_fifo merger with burst-limited grants and a zero-latency datapath.
// Optional per-channel beat counters are built when HCODE_ARB_STATS_EN is defined.
module hcode_fifo_arbiter_4ch #(
    parameter int DATA_W    = 128,
    parameter int BURST_MAX = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
`ifdef HCODE_ARB_STATS_EN
    input  logic                stat_clr,
    output logic [4*32-1:0]     stat_beats,
`endif
    input  logic [4*DATA_W-1:0] ch_dout,
    input  logic [3:0]          ch_empty_n,
    output logic [3:0]          ch_read,
    input  logic [3:0]          cfg_en,
    output logic [DATA_W-1:0]   out_din,
    input  logic                out_full_n,
    output logic                out_write,
    output logic [1:0]          grant_id,
    output logic                grant_active
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(BURST_MAX - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [1:0]        r_g;
    logic [1:0]        r_last;
    logic [7:0]        r_cnt;
    logic [1:0]        w_g_nx;
    logic [1:0]        w_last_nx;
    logic [7:0]        w_cnt_nx;
    logic [3:0]        w_req;
    logic [1:0]        w_sel;
    logic              w_any;
    logic              w_beat;
    logic [DATA_W-1:0] w_ch_word [4];

    assign w_req = ch_empty_n & cfg_en;
    assign w_any = |w_req;

    for (genvar gi = 0; gi < 4; gi++) begin : g_words
        assign w_ch_word[gi] = ch_dout[gi*DATA_W +: DATA_W];
    end

    // Round-robin pick; scanning from last+4 down to last+1 lets the nearest requester win.
    always_comb begin
        w_sel = r_last;
        for (int k = 4; k >= 1; k--) begin
            w_sel = w_req[2'(r_last + 2'(k))] ? 2'(r_last + 2'(k)) : w_sel;
        end
    end

    // Grant FSM next state plus the combinational beat strobes.
    always_comb begin
        w_state_nx = r_state;
        w_g_nx     = r_g;
        w_last_nx  = r_last;
        w_cnt_nx   = r_cnt;
        w_beat     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nx = ST_BURST;
                    w_g_nx     = w_sel;
                    w_last_nx  = w_sel;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_BURST: begin
                w_beat = w_req[r_g] & out_full_n;
                if (w_beat) begin
                    w_cnt_nx = r_cnt + 8'd1;
                end else begin
                    w_cnt_nx = r_cnt;
                end
                // A beat on the final count still counts even if the source drains at the same time.
                if (!w_req[r_g] || (w_beat && (r_cnt == CNT_LAST))) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_BURST;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
        ch_read   = w_beat ? (4'b0001 << r_g) : 4'b0000;
        out_write = w_beat;
    end

    // Grant FSM state registers.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= ST_IDLE;
            r_g     <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_g     <= w_g_nx;
            r_last  <= w_last_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign out_din      = w_ch_word[r_g];
    assign grant_id     = r_g;
    assign grant_active = (r_state == ST_BURST);

`ifdef HCODE_ARB_STATS_EN
    logic [31:0] r_stat [4];

    // Per-channel beat counters; a clear wins over a coincident beat.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < 4; i++) begin
                r_stat[i] <= 32'd0;
            end
        end else if (stat_clr) begin
            for (int i = 0; i < 4; i++) begin
                r_stat[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_stat[i] <= ch_read[i] ? (r_stat[i] + 32'd1) : r_stat[i];
            end
        end
    end

    for (genvar gs = 0; gs < 4; gs++) begin : g_stats
        assign stat_beats[gs*32 +: 32] = r_stat[gs];
    end
`endif

endmodule
